// File: rtl/pio_bus_if_if.sv
// ---------------------------------------------------------------------------
// pio_bus_if_if -- Z80 I/O bus bundle between the CPU side and the PIO decoder
//
// Signals:
//   ena     CPU clock enable; bus inputs are only meaningful when ena=1
//   addr    Z80 address bus A[7:0]
//   iorq_n  I/O request strobe, active-low
//   rd_n    read strobe, active-low
//   wr_n    write strobe, active-low
//   m1_n    M1 strobe, active-low (with iorq_n low = interrupt acknowledge)
//   ce_n    PIO chip enable, active-low
//   basel   port B/A select (latched A0)
//   cdsel   control/data select (latched A1)
//   wr_stb  one-clock write strobe into the PIO register file
//   rd_act  high while a PIO read cycle is in progress
//   intack  high during an interrupt-acknowledge cycle
//   wait_n  wait request back to the Z80, active-low
//
// Modports:
//   master  the CPU side: drives the Z80 strobes, observes the decoder outputs
//   slave   the decoder: samples the Z80 strobes, drives the PIO/CPU controls
// ---------------------------------------------------------------------------
interface pio_bus_if_if;
  logic       ena;
  logic [7:0] addr;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic       m1_n;

  logic       ce_n;
  logic       basel;
  logic       cdsel;
  logic       wr_stb;
  logic       rd_act;
  logic       intack;
  logic       wait_n;

  modport master (
    output ena, addr, iorq_n, rd_n, wr_n, m1_n,
    input  ce_n, basel, cdsel, wr_stb, rd_act, intack, wait_n
  );

  modport slave (
    input  ena, addr, iorq_n, rd_n, wr_n, m1_n,
    output ce_n, basel, cdsel, wr_stb, rd_act, intack, wait_n
  );
endinterface

// File: rtl/pio_bus_if.sv
// ---------------------------------------------------------------------------
// pio_bus_if -- Z80 I/O bus decoder for a 4-port PIO window
//
// Decodes Z80 I/O cycles aimed at BASE[7:2] and turns them into the PIO's
// chip enable, register selects, a single-clock write strobe and a read
// activity flag. Interrupt-acknowledge cycles (IORQ with M1) are flagged
// separately and never enable the chip.
//
// Parameters:
//   BASE   I/O base address of the window; addr[1:0] select the register
//
// Ports:
//   clk_i  system clock (the only clock)
//   rst_i  synchronous, active-high reset
//   bus    pio_bus_if_if.slave bundle (Z80 strobes in, PIO controls out)
//
// Configuration macro:
//   PIO_IOWAIT_EN  when defined, every PIO access inserts one wait state
//                  (wait_n low for one ENA cycle); when undefined, wait_n
//                  is tied high and the WAIT state does not exist.
// ---------------------------------------------------------------------------
module pio_bus_if #(
  parameter logic [7:0] BASE = 8'hE8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pio_bus_if_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
`ifdef PIO_IOWAIT_EN
    WAIT   = 3'd2,
`endif
    HOLD   = 3'd3,
    ACK    = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic ce_n_q,   ce_n_d;
  logic basel_q,  basel_d;
  logic cdsel_q,  cdsel_d;
  logic wr_stb_q, wr_stb_d;
  logic rd_act_q, rd_act_d;
  logic intack_q, intack_d;
  // Set once iorq_n has been seen high; keeps a cycle that was already
  // running when reset released from being picked up half-way through.
  logic armed_q,  armed_d;
  logic go_idle;
  logic addr_hit;

`ifdef PIO_IOWAIT_EN
  logic wait_n_q, wait_n_d;
`endif

  assign addr_hit = (bus.addr[7:2] == BASE[7:2]);

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ce_n_q   <= 1'b1;
      basel_q  <= 1'b0;
      cdsel_q  <= 1'b0;
      wr_stb_q <= 1'b0;
      rd_act_q <= 1'b0;
      intack_q <= 1'b0;
      armed_q  <= 1'b0;
`ifdef PIO_IOWAIT_EN
      wait_n_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      ce_n_q   <= ce_n_d;
      basel_q  <= basel_d;
      cdsel_q  <= cdsel_d;
      wr_stb_q <= wr_stb_d;
      rd_act_q <= rd_act_d;
      intack_q <= intack_d;
      armed_q  <= armed_d;
`ifdef PIO_IOWAIT_EN
      wait_n_q <= wait_n_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    ce_n_d   = ce_n_q;
    basel_d  = basel_q;
    cdsel_d  = cdsel_q;
    wr_stb_d = 1'b0;
    rd_act_d = rd_act_q;
    intack_d = intack_q;
    armed_d  = armed_q;
    go_idle  = 1'b0;
`ifdef PIO_IOWAIT_EN
    wait_n_d = wait_n_q;
`endif

    if (bus.ena && bus.iorq_n) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.ena && !bus.iorq_n && armed_q) begin
          if (!bus.m1_n) begin
            state_d  = ACK;
            intack_d = 1'b1;
          end else if (addr_hit) begin
            state_d  = ACCESS;
            ce_n_d   = 1'b0;
            basel_d  = bus.addr[0];
            cdsel_d  = bus.addr[1];
            // The strobe is registered on entry so it is high for exactly
            // the single clock spent in ACCESS. Simultaneous RD/WR counts
            // as a write, so the read flag also needs wr_n high.
            wr_stb_d = ~bus.wr_n;
            rd_act_d = ~bus.rd_n & bus.wr_n;
          end
        end
      end

      // ACCESS lasts one clock whatever ENA does, so the strobe never
      // stretches when the CPU is being clock-gated.
      ACCESS: begin
        if (bus.ena && bus.iorq_n) begin
          go_idle = 1'b1;
        end else begin
`ifdef PIO_IOWAIT_EN
          state_d  = WAIT;
          wait_n_d = 1'b0;
`else
          state_d  = HOLD;
`endif
        end
      end

`ifdef PIO_IOWAIT_EN
      WAIT: begin
        if (bus.ena) begin
          wait_n_d = 1'b1;
          if (bus.iorq_n) begin
            go_idle = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
`endif

      HOLD: begin
        if (bus.ena && bus.iorq_n) begin
          go_idle = 1'b1;
        end
      end

      ACK: begin
        if (bus.ena && bus.iorq_n) begin
          state_d  = IDLE;
          intack_d = 1'b0;
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_d  = IDLE;
      ce_n_d   = 1'b1;
      basel_d  = 1'b0;
      cdsel_d  = 1'b0;
      rd_act_d = 1'b0;
      intack_d = 1'b0;
`ifdef PIO_IOWAIT_EN
      wait_n_d = 1'b1;
`endif
    end
  end

  assign bus.ce_n   = ce_n_q;
  assign bus.basel  = basel_q;
  assign bus.cdsel  = cdsel_q;
  assign bus.wr_stb = wr_stb_q;
  assign bus.rd_act = rd_act_q;
  assign bus.intack = intack_q;
`ifdef PIO_IOWAIT_EN
  assign bus.wait_n = wait_n_q;
`else
  assign bus.wait_n = 1'b1;
`endif

endmodule
